// File: rtl/vga_render_pkg.sv
// -----------------------------------------------------------------------------
// vga_render_pkg
//   Shared types and constants for the VGA circle overlay renderer.
//   COORD_W / PIXEL_W size every coordinate and colour field in the design.
//   Colours are RRRGGGBB.
//   circle_cfg_t is the per-slot record held in both the shadow and the active
//   bank.
//   Optional feature macro: CIRCLE_OUTLINE_EN adds the ring band (lo/hi) and the
//   outline flag to the record.
// -----------------------------------------------------------------------------
package vga_render_pkg;

  localparam int COORD_W = 11;
  localparam int PIXEL_W = 8;

  localparam logic [PIXEL_W-1:0] BLACK  = 8'h00;
  localparam logic [PIXEL_W-1:0] RED    = 8'hE0;
  localparam logic [PIXEL_W-1:0] GREEN  = 8'h1C;
  localparam logic [PIXEL_W-1:0] BLUE   = 8'h03;
  localparam logic [PIXEL_W-1:0] YELLOW = 8'hFC;
  localparam logic [PIXEL_W-1:0] WHITE  = 8'hFF;

  typedef enum logic {
    IDLE,
    CALC
  } cfgState_t;

  typedef struct packed {
    logic [COORD_W-1:0]   cx;
    logic [COORD_W-1:0]   cy;
    logic [2*COORD_W-1:0] rsq;
`ifdef CIRCLE_OUTLINE_EN
    logic [2*COORD_W:0]   lo;
    logic [2*COORD_W:0]   hi;
    logic                 outline;
`endif
    logic [PIXEL_W-1:0]   colour;
    logic                 en;
  } circle_cfg_t;

endpackage

// File: rtl/circle_hit_unit.sv
// -----------------------------------------------------------------------------
// circle_hit_unit
//   Three-stage distance test of the current pixel against one circle slot.
//   The slot settings are captured together with dx/dy in S1 and carried down
//   the pipe, so the test always uses the bank that was active at S1 time.
//   Ports:
//     clk, resetn     pixel clock, synchronous active-low reset
//     hcount, vcount  pixel position
//     cfg             active-bank settings of this slot
//     hit             combinational S3 result (registered by the top level)
//     colour          slot colour aligned with hit
//   Optional feature macro: CIRCLE_OUTLINE_EN (ring mode using lo/hi).
// -----------------------------------------------------------------------------
module circle_hit_unit
  import vga_render_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  circle_cfg_t        cfg,
  output logic               hit,
  output logic [PIXEL_W-1:0] colour
);

  logic signed [COORD_W:0] dx, dy;
  logic [2*COORD_W:0]      sqX, sqY, d2;
  logic [2*COORD_W-1:0]    s1Rsq, s2Rsq;
  logic [PIXEL_W-1:0]      s1Colour, s2Colour;
  logic                    s1En, s2En;
`ifdef CIRCLE_OUTLINE_EN
  logic [2*COORD_W:0]      s1Lo, s1Hi, s2Lo, s2Hi;
  logic                    s1Outline, s2Outline;
`endif

  // |dx| <= 2047, so each square fits in 22 bits and the sum in 23 bits.
  assign sqX = (2*COORD_W+1)'(dx * dx);
  assign sqY = (2*COORD_W+1)'(dy * dy);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx       <= '0;
      dy       <= '0;
      d2       <= '0;
      s1Rsq    <= '0;
      s2Rsq    <= '0;
      s1Colour <= '0;
      s2Colour <= '0;
      s1En     <= 1'b0;
      s2En     <= 1'b0;
`ifdef CIRCLE_OUTLINE_EN
      s1Lo      <= '0;
      s1Hi      <= '0;
      s2Lo      <= '0;
      s2Hi      <= '0;
      s1Outline <= 1'b0;
      s2Outline <= 1'b0;
`endif
    end else begin
      dx       <= $signed({1'b0, hcount}) - $signed({1'b0, cfg.cx});
      dy       <= $signed({1'b0, vcount}) - $signed({1'b0, cfg.cy});
      s1Rsq    <= cfg.rsq;
      s1Colour <= cfg.colour;
      s1En     <= cfg.en;
      d2       <= sqX + sqY;
      s2Rsq    <= s1Rsq;
      s2Colour <= s1Colour;
      s2En     <= s1En;
`ifdef CIRCLE_OUTLINE_EN
      s1Lo      <= cfg.lo;
      s1Hi      <= cfg.hi;
      s1Outline <= cfg.outline;
      s2Lo      <= s1Lo;
      s2Hi      <= s1Hi;
      s2Outline <= s1Outline;
`endif
    end
  end

  always_comb begin
    hit = 1'b0;
`ifdef CIRCLE_OUTLINE_EN
    if (s2Outline) hit = s2En && (d2 >= s2Lo) && (d2 <= s2Hi);
    else           hit = s2En && (d2 <= {1'b0, s2Rsq});
`else
    hit = s2En && (d2 <= {1'b0, s2Rsq});
`endif
  end

  assign colour = s2Colour;

endmodule

// File: rtl/circle_renderer.sv
// -----------------------------------------------------------------------------
// circle_renderer
//   Multi-circle overlay renderer. Circles are written into a shadow bank via a
//   two-state config FSM (one write per two cycles) and copied to the active
//   bank on frame_start, so a frame never mixes old and new settings.
//   Pixel output latency is 3 clocks, one pixel per clock.
//   Ports:
//     clk, resetn          pixel clock, synchronous active-low reset
//     hcount/vcount/blank  VGA timing inputs
//     frame_start          one-cycle pulse at start of frame (commit point)
//     cfg_*                config write channel (valid/ready handshake)
//     cfg_outline          ring mode select (only with CIRCLE_OUTLINE_EN)
//     pixel, blank_out     rendered pixel and aligned blank
//     commit_done          pulse the cycle after a shadow->active copy
//   Optional feature macro: CIRCLE_OUTLINE_EN.
//   COORD_W and PIXEL_W come from vga_render_pkg.
// -----------------------------------------------------------------------------
module circle_renderer
  import vga_render_pkg::*;
#(
  parameter int                 NUM_CIRCLES = 4,
  parameter int                 TOL_SHIFT   = 7,
  parameter logic [PIXEL_W-1:0] BG_COLOUR   = BLACK,
  parameter int                 IDX_W       = (NUM_CIRCLES > 1) ? $clog2(NUM_CIRCLES) : 1
)(
  input  logic               clk,
  input  logic               resetn,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               blank,
  input  logic               frame_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_cx,
  input  logic [COORD_W-1:0] cfg_cy,
  input  logic [COORD_W-1:0] cfg_rad,
  input  logic [PIXEL_W-1:0] cfg_colour,
  input  logic               cfg_en,
`ifdef CIRCLE_OUTLINE_EN
  input  logic               cfg_outline,
`endif
  output logic [PIXEL_W-1:0] pixel,
  output logic               blank_out,
  output logic               commit_done
);

  cfgState_t            state, stateNext;
  logic [IDX_W-1:0]     latIdx;
  logic [COORD_W-1:0]   latCx, latCy, latRad;
  logic [PIXEL_W-1:0]   latColour;
  logic                 latEn;
`ifdef CIRCLE_OUTLINE_EN
  logic                 latOutline;
  logic [2*COORD_W-1:0] calcTol;
`endif
  logic [2*COORD_W-1:0] calcRsq;
  logic                 idxValid;
  circle_cfg_t          newCfg;
  circle_cfg_t          shadowBank [NUM_CIRCLES];
  circle_cfg_t          activeBank [NUM_CIRCLES];
  logic                 pending;
  logic                 commitPulse;
  logic                 hitVec     [NUM_CIRCLES];
  logic [PIXEL_W-1:0]   hitColour  [NUM_CIRCLES];
  logic [PIXEL_W-1:0]   winColour;
  logic                 blankD1, blankD2;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) stateNext = CALC;
      end
      CALC:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      latIdx    <= '0;
      latCx     <= '0;
      latCy     <= '0;
      latRad    <= '0;
      latColour <= '0;
      latEn     <= 1'b0;
`ifdef CIRCLE_OUTLINE_EN
      latOutline <= 1'b0;
`endif
    end else if (state == IDLE && cfg_valid) begin
      latIdx    <= cfg_idx;
      latCx     <= cfg_cx;
      latCy     <= cfg_cy;
      latRad    <= cfg_rad;
      latColour <= cfg_colour;
      latEn     <= cfg_en;
`ifdef CIRCLE_OUTLINE_EN
      latOutline <= cfg_outline;
`endif
    end
  end

  // Slot record computed during CALC from the latched request.
  assign calcRsq  = latRad * latRad;
  assign idxValid = int'(latIdx) < NUM_CIRCLES;

  always_comb begin
    newCfg        = '0;
    newCfg.cx     = latCx;
    newCfg.cy     = latCy;
    newCfg.rsq    = calcRsq;
    newCfg.colour = latColour;
    newCfg.en     = latEn;
`ifdef CIRCLE_OUTLINE_EN
    calcTol        = calcRsq >> TOL_SHIFT;
    newCfg.lo      = {1'b0, calcRsq} - {1'b0, calcTol};
    newCfg.hi      = {1'b0, calcRsq} + {1'b0, calcTol};
    newCfg.outline = latOutline;
`endif
  end

  // The commit copies the shadow contents from before this edge; a CALC write
  // on the same edge therefore lands in shadow only and re-arms pending.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        shadowBank[i] <= '0;
        activeBank[i] <= '0;
      end
      pending     <= 1'b0;
      commitPulse <= 1'b0;
    end else begin
      commitPulse <= frame_start && pending;
      if (frame_start && pending) begin
        for (int i = 0; i < NUM_CIRCLES; i++) activeBank[i] <= shadowBank[i];
        pending <= 1'b0;
      end
      if (state == CALC && idxValid) begin
        for (int i = 0; i < NUM_CIRCLES; i++) begin
          if (int'(latIdx) == i) shadowBank[i] <= newCfg;
        end
        pending <= 1'b1;
      end
    end
  end

  assign commit_done = commitPulse;

  for (genvar g = 0; g < NUM_CIRCLES; g++) begin : gHit
    circle_hit_unit uHit (
      .clk    (clk),
      .resetn (resetn),
      .hcount (hcount),
      .vcount (vcount),
      .cfg    (activeBank[g]),
      .hit    (hitVec[g]),
      .colour (hitColour[g])
    );
  end

  // Scan from the top slot down so the lowest hitting index wins.
  always_comb begin
    winColour = BG_COLOUR;
    for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
      if (hitVec[i]) winColour = hitColour[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      blankD1   <= 1'b1;
      blankD2   <= 1'b1;
      blank_out <= 1'b1;
      pixel     <= BG_COLOUR;
    end else begin
      blankD1   <= blank;
      blankD2   <= blankD1;
      blank_out <= blankD2;
      pixel     <= blankD2 ? BG_COLOUR : winColour;
    end
  end

endmodule

// File: tb/tb_circle_renderer.sv
// -----------------------------------------------------------------------------
// tb_circle_renderer
//   Scoreboard bench for circle_renderer: every driven pixel pushes its
//   expected {blank_out, pixel} from a behavioural circle model; a monitor pops
//   and compares three clocks later. Config/commit handshakes are checked inline.
//   Optional feature macro: CIRCLE_OUTLINE_EN (ring tests).
// -----------------------------------------------------------------------------
module tb_circle_renderer;
  import vga_render_pkg::*;

  localparam int NUM = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic [COORD_W-1:0] hcount, vcount;
  logic               blank, frame_start;
  logic               cfg_valid, cfg_ready;
  logic [1:0]         cfg_idx;
  logic [COORD_W-1:0] cfg_cx, cfg_cy, cfg_rad;
  logic [PIXEL_W-1:0] cfg_colour;
  logic               cfg_en;
`ifdef CIRCLE_OUTLINE_EN
  logic               cfg_outline;
`endif
  logic [PIXEL_W-1:0] pixel;
  logic               blank_out, commit_done;

  always #5 clk = ~clk;

  circle_renderer #(.NUM_CIRCLES(NUM)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .hcount      (hcount),
    .vcount      (vcount),
    .blank       (blank),
    .frame_start (frame_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_idx     (cfg_idx),
    .cfg_cx      (cfg_cx),
    .cfg_cy      (cfg_cy),
    .cfg_rad     (cfg_rad),
    .cfg_colour  (cfg_colour),
    .cfg_en      (cfg_en),
`ifdef CIRCLE_OUTLINE_EN
    .cfg_outline (cfg_outline),
`endif
    .pixel       (pixel),
    .blank_out   (blank_out),
    .commit_done (commit_done)
  );

  typedef struct {
    int         stamp;
    int         h;
    int         v;
    logic [8:0] exp;
  } sbEntry_t;

  typedef struct {
    int         cx;
    int         cy;
    int         r;
    logic [7:0] col;
    bit         en;
    bit         outline;
  } modelCirc_t;

  sbEntry_t   sbQ[$];
  modelCirc_t mShadow [NUM];
  modelCirc_t mActive [NUM];
  bit         mPending;
  int         cycleCount = 0;
  int         vecCount   = 0;
  int         missCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] expPixel(input int h, input int v, input bit b);
    longint dxx, dyy, d2, rsq, tol;
    bit     hitv;
    if (b) return 8'h00;
    for (int i = 0; i < NUM; i++) begin
      if (mActive[i].en) begin
        dxx = h - mActive[i].cx;
        dyy = v - mActive[i].cy;
        d2  = dxx * dxx + dyy * dyy;
        rsq = longint'(mActive[i].r) * mActive[i].r;
        if (mActive[i].outline) begin
          tol  = rsq >> 7;
          hitv = (d2 >= rsq - tol) && (d2 <= rsq + tol);
        end else begin
          hitv = (d2 <= rsq);
        end
        if (hitv) return mActive[i].col;
      end
    end
    return 8'h00;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM; i++) begin
      mShadow[i] = '{0, 0, 0, 8'h00, 1'b0, 1'b0};
      mActive[i] = '{0, 0, 0, 8'h00, 1'b0, 1'b0};
    end
    mPending = 1'b0;
  endfunction

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Each pushed pixel is due exactly three clocks after it was driven.
  always @(posedge clk) begin
    sbEntry_t e;
    #1;
    if (sbQ.size() > 0 && sbQ[0].stamp + 3 == cycleCount) begin
      e = sbQ.pop_front();
      checkOutput($sformatf("pix(%0d,%0d)", e.h, e.v), {23'd0, blank_out, pixel}, {23'd0, e.exp});
    end
  end

  task automatic applyStimulus(input int h, input int v, input bit b);
    sbEntry_t e;
    @(negedge clk);
    hcount = h[COORD_W-1:0];
    vcount = v[COORD_W-1:0];
    blank  = b;
    e.stamp = cycleCount;
    e.h     = h;
    e.v     = v;
    e.exp   = {b, expPixel(h, v, b)};
    sbQ.push_back(e);
  endtask

  task automatic pulseFrameStart();
    bit committed;
    @(negedge clk);
    frame_start = 1'b1;
    blank       = 1'b1;
    committed   = mPending;
    if (mPending) begin
      mActive  = mShadow;
      mPending = 1'b0;
    end
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("commitDone", {31'd0, commit_done}, {31'd0, committed});
    @(negedge clk);
    checkOutput("commitDoneLow", {31'd0, commit_done}, 32'd0);
  endtask

  task automatic writeCircle(input int idx, input int cx, input int cy, input int r,
                             input logic [7:0] col, input bit en, input bit outl,
                             input bit fsOnCalc);
    int waitCnt;
    bit committed;
    waitCnt   = 0;
    committed = 1'b0;
    @(negedge clk);
    while (!cfg_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cfg_ready) begin
      checkOutput("cfgReadyWait", {31'd0, cfg_ready}, 32'd1);
      return;
    end
    cfg_valid  = 1'b1;
    cfg_idx    = idx[1:0];
    cfg_cx     = cx[COORD_W-1:0];
    cfg_cy     = cy[COORD_W-1:0];
    cfg_rad    = r[COORD_W-1:0];
    cfg_colour = col;
    cfg_en     = en;
`ifdef CIRCLE_OUTLINE_EN
    cfg_outline = outl;
`endif
    @(negedge clk);
    cfg_valid = 1'b0;
    checkOutput("cfgReadyLow", {31'd0, cfg_ready}, 32'd0);
    if (fsOnCalc) begin
      frame_start = 1'b1;
      blank       = 1'b1;
      committed   = mPending;
      if (mPending) mActive = mShadow;
    end
    mShadow[idx].cx  = cx;
    mShadow[idx].cy  = cy;
    mShadow[idx].r   = r;
    mShadow[idx].col = col;
    mShadow[idx].en  = en;
`ifdef CIRCLE_OUTLINE_EN
    mShadow[idx].outline = outl;
`else
    mShadow[idx].outline = 1'b0;
    if (outl) mShadow[idx].outline = 1'b0;
`endif
    mPending = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("cfgReadyHigh", {31'd0, cfg_ready}, 32'd1);
    if (fsOnCalc) checkOutput("commitDoneOnCalc", {31'd0, commit_done}, {31'd0, committed});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0; blank = 1'b1; frame_start = 1'b0;
    hcount = '0; vcount = '0;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_cx = '0; cfg_cy = '0; cfg_rad = '0;
    cfg_colour = '0; cfg_en = 1'b0;
`ifdef CIRCLE_OUTLINE_EN
    cfg_outline = 1'b0;
`endif
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstPixel",      {24'd0, pixel},       32'h00);
    checkOutput("rstBlankOut",   {31'd0, blank_out},   32'd1);
    checkOutput("rstCfgReady",   {31'd0, cfg_ready},   32'd1);
    checkOutput("rstCommitDone", {31'd0, commit_done}, 32'd0);
    resetn = 1'b1;

    $display("[TB] test 1: unconfigured frame renders background");
    pulseFrameStart();
    for (int v = 0; v < 4; v++)
      for (int h = 1; h <= 20; h++)
        applyStimulus(h, v, (h > 16) || (v == 3));

    $display("[TB] test 2: filled circle slot 0");
    writeCircle(0, 320, 240, 10, 8'hE0, 1'b1, 1'b0, 1'b0);
    pulseFrameStart();
    applyStimulus(320, 240, 1'b0);
    applyStimulus(330, 240, 1'b0);
    applyStimulus(331, 240, 1'b0);
    applyStimulus(320, 230, 1'b0);
    applyStimulus(320, 229, 1'b0);
    applyStimulus(313, 233, 1'b0);
    applyStimulus(312, 232, 1'b0);
    applyStimulus(320, 240, 1'b1);

    $display("[TB] test 3: mid-frame write waits for frame_start");
    writeCircle(1, 400, 240, 5, 8'h1C, 1'b1, 1'b0, 1'b0);
    applyStimulus(400, 240, 1'b0);
    applyStimulus(405, 240, 1'b0);
    pulseFrameStart();
    applyStimulus(400, 240, 1'b0);
    applyStimulus(405, 240, 1'b0);
    applyStimulus(406, 240, 1'b0);

    $display("[TB] test 4: overlap priority");
    writeCircle(0, 100, 100, 20, 8'hE0, 1'b1, 1'b0, 1'b0);
    writeCircle(1, 100, 100, 20, 8'h1C, 1'b1, 1'b0, 1'b0);
    pulseFrameStart();
    applyStimulus(100, 100, 1'b0);
    applyStimulus(120, 100, 1'b0);
    applyStimulus(121, 100, 1'b0);
    writeCircle(0, 100, 100, 20, 8'hE0, 1'b0, 1'b0, 1'b0);
    pulseFrameStart();
    applyStimulus(100, 100, 1'b0);
    applyStimulus(100, 80, 1'b0);

`ifdef CIRCLE_OUTLINE_EN
    $display("[TB] test 5: outline ring");
    writeCircle(2, 320, 240, 180, 8'hFC, 1'b1, 1'b1, 1'b0);
    pulseFrameStart();
    applyStimulus(500, 240, 1'b0);
    applyStimulus(320, 240, 1'b0);
    applyStimulus(500, 241, 1'b0);
    applyStimulus(497, 240, 1'b0);
    applyStimulus(320, 419, 1'b0);
`endif

    $display("[TB] test 6: write completing on frame_start");
    writeCircle(2, 50, 50, 3, 8'h03, 1'b1, 1'b0, 1'b0);
    writeCircle(3, 60, 60, 3, 8'hFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(50, 50, 1'b0);
    applyStimulus(60, 60, 1'b0);
    applyStimulus(50, 50, 1'b1);
    pulseFrameStart();
    applyStimulus(60, 60, 1'b0);
    applyStimulus(63, 60, 1'b0);
    applyStimulus(64, 60, 1'b0);

    $display("[TB] test 7: reset during CALC");
    repeat (5) @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = 2'd3; cfg_cx = 11'd60; cfg_cy = 11'd60;
    cfg_rad = 11'd3; cfg_colour = 8'h1C; cfg_en = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    resetn    = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    modelReset();
    checkOutput("rstMidCfgReady", {31'd0, cfg_ready}, 32'd1);
    pulseFrameStart();
    applyStimulus(60, 60, 1'b0);
    applyStimulus(50, 50, 1'b0);

    repeat (6) @(negedge clk);
    checkOutput("sbDrain", sbQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
